// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and default stall-bus width for the pipeline controller.
package pipe_ctrl_pkg;
    localparam int STALL_BUS = 6;
    typedef enum logic [1:0] {PC_RUN, PC_HOLD, PC_FWAIT, PC_FLUSH} pc_state_e;
endpackage

// File: rtl/pipe_ctrl_stall_therm.sv
// pipe_ctrl_stall_therm: highest-set-bit to thermometer mask; bit j is set when any request at or above j is set.
module pipe_ctrl_stall_therm #(
    parameter int N = 6
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] mask_o
);
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign mask_o[i] = |req_i[N-1:i];
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage stall vector, timed holds, deferred flush with redirect PC and a saturating stall counter.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int N_STAGES    = STALL_BUS,
    parameter int HOLD_CYCLES = 1,
    parameter int PC_W        = 32,
    parameter int CNT_W       = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_STAGES-1:0] stallreq_i,
    input  logic [N_STAGES-1:0] timed_req_i,
    input  logic                mem_busy_i,
    input  logic                flush_req_i,
    input  logic [PC_W-1:0]     flush_pc_i,
    input  logic                perf_clr_i,
    output logic [N_STAGES-1:0] stall_o,
    output logic                flush_o,
    output logic [PC_W-1:0]     new_pc_o,
    output logic [CNT_W-1:0]    stall_cycles_o
);
    localparam int CW = $clog2(HOLD_CYCLES + 1);

    pc_state_e           state_q;
    logic [N_STAGES-1:0] hold_vec_q;
    logic [N_STAGES-1:0] therm;
    logic [CW-1:0]       cnt_q;
    logic [PC_W-1:0]     pc_q;
    logic [PC_W-1:0]     new_pc_q;
    logic [CNT_W-1:0]    stall_cycles_q;
    logic [CNT_W-1:0]    stall_cycles_d;

    pipe_ctrl_stall_therm #(.N(N_STAGES)) u_therm (
        .req_i  (stallreq_i | hold_vec_q),
        .mask_o (therm)
    );

    assign stall_o = (!rst_n || state_q == PC_FLUSH) ? '0 :
                     (state_q == PC_FWAIT)           ? '1 : therm;
    assign flush_o        = state_q == PC_FLUSH;
    assign new_pc_o       = new_pc_q;
    assign stall_cycles_o = stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PC_RUN;
            hold_vec_q <= '0;
            cnt_q      <= '0;
            pc_q       <= '0;
            new_pc_q   <= '0;
        end else if (state_q == PC_FWAIT) begin
            if (flush_req_i) pc_q <= flush_pc_i;
            if (!mem_busy_i) begin
                state_q  <= PC_FLUSH;
                new_pc_q <= flush_req_i ? flush_pc_i : pc_q;
            end
        end else if (flush_req_i) begin
            hold_vec_q <= '0;
            cnt_q      <= '0;
            state_q    <= mem_busy_i ? PC_FWAIT : PC_FLUSH;
            if (mem_busy_i) pc_q <= flush_pc_i;
            else new_pc_q <= flush_pc_i;
        end else if (timed_req_i != '0 && state_q != PC_FLUSH) begin
            // a new pulse during a hold merges stages and restarts the count
            state_q    <= PC_HOLD;
            hold_vec_q <= hold_vec_q | timed_req_i;
            cnt_q      <= CW'(HOLD_CYCLES);
        end else if (state_q == PC_HOLD) begin
            if (cnt_q == CW'(1)) begin
                state_q    <= PC_RUN;
                hold_vec_q <= '0;
            end
            cnt_q <= cnt_q - CW'(1);
        end else begin
            state_q <= PC_RUN;
        end
    end

    assign stall_cycles_d = perf_clr_i                    ? '0 :
                            (stall_o[0] && ~&stall_cycles_q) ? stall_cycles_q + CNT_W'(1) :
                                                            stall_cycles_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cycles_q <= '0;
        else stall_cycles_q <= stall_cycles_d;
    end
endmodule
